// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, widths and FSM states for the FFT power path
// Contents:
//   FFT_N      FFT length
//   NBIN       folded power bins (bins k and FFT_N-k combined)
//   BIN_IDX_W  width of a bin index
//   pwr_w()    power bin width for a W-bit FFT sample
//   state_t    IDLE / ACCUM / OUT sequencer states
package fft_pkg;
  localparam int FFT_N     = 32;
  localparam int NBIN      = FFT_N / 2 + 1;
  localparam int BIN_IDX_W = 5;

  function automatic int pwr_w(input int w);
    return 2 * w + 3;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;
endpackage

// File: rtl/fft_rstb_sync.sv
// rtl/fft_rstb_sync.sv - one-flop synchronised release of the asynchronous reset
// Ports:
//   clk    in   clock
//   arstb  in   asynchronous active-low reset
//   rstb   out  low during reset and for the first clk edge after release
module fft_rstb_sync (
  input  logic clk,
  input  logic arstb,
  output logic rstb
);
  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) rstb <= 1'b0;
    else        rstb <= 1'b1;
  end
endmodule

// File: rtl/fft_pwr_avg_ctrl.sv
// rtl/fft_pwr_avg_ctrl.sv - averages 2^AVG_LOG2 folded power frames and streams bins 0..16
// Ports:
//   clk, arstb  clock, asynchronous active-low reset
//   clr         synchronous abort: back to IDLE, frame count and ovr cleared
//   pwr_in      NBIN bins of PW bits, bin k at [k*PW +: PW]
//   pwr_valid   new frame on pwr_in; in_ready high when it can be captured
//   out_valid   out_data/out_bin valid; out_ready accepts
//   out_data    averaged power (truncated) for out_bin
//   done        one-cycle pulse after bin 16 is accepted
//   ovr         sticky: frame offered while in_ready was low
module fft_pwr_avg_ctrl
  import fft_pkg::*;
#(
  parameter  int W        = 8,
  parameter  int AVG_LOG2 = 2,
  localparam int PW       = pwr_w(W)
) (
  input  logic                 clk,
  input  logic                 arstb,
  input  logic                 clr,
  input  logic [NBIN*PW-1:0]   pwr_in,
  input  logic                 pwr_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PW-1:0]        out_data,
  output logic [BIN_IDX_W-1:0] out_bin,
  output logic                 done,
  output logic                 ovr
);
  localparam int AW  = PW + AVG_LOG2;
  localparam int FCW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [FCW-1:0]       FC_LAST  = FCW'((1 << AVG_LOG2) - 1);
  localparam logic [BIN_IDX_W-1:0] LAST_BIN = BIN_IDX_W'(NBIN - 1);

  logic                 rstb;
  state_t               state;
  logic [BIN_IDX_W-1:0] idx;
  logic [FCW-1:0]       frame_cnt;
  logic [PW-1:0]        snap [NBIN];
  logic [AW-1:0]        acc  [NBIN];
  logic [AW-1:0]        acc_sum;
  logic [BIN_IDX_W-1:0] rd_idx;
  logic [PW-1:0]        rd_data;

  fft_rstb_sync u_rstb_sync (
    .clk   (clk),
    .arstb (arstb),
    .rstb  (rstb)
  );

  // Single shared adder; the first frame of a batch overwrites stale sums.
  always_comb begin
    acc_sum = ((frame_cnt == '0) ? '0 : acc[idx]) + AW'(snap[idx]);
  end

  // Output read port: the bin about to be presented (next one after an accept).
  always_comb begin
    rd_idx  = (out_valid && idx != LAST_BIN) ? idx + 1'b1 : idx;
    rd_data = PW'(acc[rd_idx] >> AVG_LOG2);
  end

  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) begin
      for (int k = 0; k < NBIN; k++) begin
        snap[k] <= '0;
        acc[k]  <= '0;
      end
    end else if (rstb && !clr) begin
      if (state == IDLE && pwr_valid && in_ready) begin
        for (int k = 0; k < NBIN; k++) snap[k] <= pwr_in[k*PW +: PW];
      end
      if (state == ACCUM) acc[idx] <= acc_sum;
    end
  end

  always_ff @(posedge clk or negedge arstb) begin
    if (!arstb) begin
      state     <= IDLE;
      idx       <= '0;
      frame_cnt <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_bin   <= '0;
      done      <= 1'b0;
      ovr       <= 1'b0;
    end else if (!rstb || clr) begin
      // Next state is IDLE in both cases, so in_ready rises with it.
      state     <= IDLE;
      idx       <= '0;
      frame_cnt <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_bin   <= '0;
      done      <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (pwr_valid && !in_ready) ovr <= 1'b1;
      case (state)
        IDLE: begin
          if (pwr_valid && in_ready) begin
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (idx == LAST_BIN) begin
            idx <= '0;
            if (frame_cnt == FC_LAST) begin
              frame_cnt <= '0;
              state     <= OUT;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
              in_ready  <= 1'b1;
              state     <= IDLE;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        OUT: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_bin   <= idx;
            out_data  <= rd_data;
          end else if (out_ready) begin
            if (idx == LAST_BIN) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              idx       <= '0;
              in_ready  <= 1'b1;
              state     <= IDLE;
            end else begin
              idx      <= idx + 1'b1;
              out_bin  <= idx + 1'b1;
              out_data <= rd_data;
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fft_pwr_avg_ctrl.sv
// tb/tb_fft_pwr_avg_ctrl.sv - scoreboard bench for fft_pwr_avg_ctrl
module tb_fft_pwr_avg_ctrl;
  localparam int W  = 8;
  localparam int AL = 2;
  localparam int NB = 17;
  localparam int PW = 2 * W + 3;

  typedef struct packed {
    logic [4:0]    bin;
    logic [PW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            arstb = 1'b1;
  logic            clr = 1'b0;
  logic            pwr_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic [NB*PW-1:0] pwr_in = '0;
  logic            in_ready, out_valid, done, ovr;
  logic [PW-1:0]   out_data;
  logic [4:0]      out_bin;

  exp_t sb[$];
  exp_t e;
  int   checks = 0, failures = 0;
  int   done_cnt = 0, cyc = 0, first_acc = -1, last_acc = -1, valid_seen = 0;
  int   d0, n;
  logic bp_mode = 1'b0;
  logic prev_acc16 = 1'b0, prev_stall = 1'b0;
  logic [PW-1:0] prev_data = '0;
  logic [4:0]    prev_bin = '0;

  fft_pwr_avg_ctrl #(.W(W), .AVG_LOG2(AL)) dut (
    .clk       (clk),
    .arstb     (arstb),
    .clr       (clr),
    .pwr_in    (pwr_in),
    .pwr_valid (pwr_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_bin   (out_bin),
    .done      (done),
    .ovr       (ovr)
  );

  always #5 clk = ~clk;

  // out_ready: always 1, or 1,0,0,1 repeating in backpressure mode.
  always @(posedge clk) begin
    cyc++;
    #1;
    out_ready = bp_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
  end

  // Monitor: pops the scoreboard on every accepted output.
  always @(negedge clk) begin
    if (prev_acc16 || done) begin
      checks++;
      if (done !== prev_acc16) begin
        failures++;
        $display("FAIL done_pulse: done=%0b expected=%0b", done, prev_acc16);
      end
    end
    if (done) done_cnt++;
    if (prev_stall && arstb) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== prev_data || out_bin !== prev_bin) begin
        failures++;
        $display("FAIL stall_hold: valid=%0b bin=%0d data=%0d expected valid=1 bin=%0d data=%0d",
                 out_valid, out_bin, out_data, prev_bin, prev_data);
      end
    end
    if (out_valid) valid_seen++;
    if (out_valid && out_ready) begin
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output: bin=%0d data=%0d expected none", out_bin, out_data);
      end else begin
        e = sb.pop_front();
        if (out_bin !== e.bin || out_data !== e.data) begin
          failures++;
          $display("FAIL out_beat: bin=%0d data=%0d expected bin=%0d data=%0d",
                   out_bin, out_data, e.bin, e.data);
        end
      end
    end
    prev_acc16 = out_valid && out_ready && (out_bin == 5'd16);
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_bin   = out_bin;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected averaged spectrum: bin k = mul*k + off.
  task automatic push_exp(input int mul, input int off);
    exp_t x;
    for (int k = 0; k < NB; k++) begin
      x.bin  = 5'(k);
      x.data = PW'(mul * k + off);
      sb.push_back(x);
    end
  endtask

  // Frame with bin k = mul*k + off; called and returns at posedge+1.
  task automatic send_frame(input int mul, input int off);
    int t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    for (int k = 0; k < NB; k++) pwr_in[k*PW +: PW] = PW'(mul * k + off);
    pwr_valid = 1'b1;
    @(posedge clk); #1;
    pwr_valid = 1'b0;
  endtask

  task automatic drain(input int start_done);
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (3) begin @(posedge clk); #1; end
    check("sb_empty", sb.size(), 0);
    check("done_count", done_cnt - start_done, 1);
  endtask

  initial begin
    #2 arstb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // 1. reset
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_done_ovr", {done, ovr}, 0);
    check("rst_data_bin", {out_data, out_bin}, 0);
    @(negedge clk);
    arstb = 1'b1;
    #1;
    check("in_ready_rel_cycle1", in_ready, 0);
    @(posedge clk); #1;
    check("in_ready_rel_cycle2", in_ready, 1);

    // 2. average of four frames, out_ready=1
    d0 = done_cnt;
    first_acc = -1;
    push_exp(100, 6);
    for (int f = 0; f < 4; f++) send_frame(100, 4 * f);
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    check("first_valid_latency", n, 18);
    drain(d0);
    check("consecutive_beats", last_acc - first_acc, 16);

    // 3. backpressure 1,0,0,1
    bp_mode = 1'b1;
    d0 = done_cnt;
    push_exp(100, 6);
    for (int f = 0; f < 4; f++) send_frame(100, 4 * f);
    drain(d0);
    bp_mode = 1'b0;

    // 4. overrun during ACCUM
    check("ovr_before", ovr, 0);
    d0 = done_cnt;
    push_exp(100, 6);
    send_frame(100, 0);
    send_frame(100, 4);
    repeat (4) begin @(posedge clk); #1; end
    for (int k = 0; k < NB; k++) pwr_in[k*PW +: PW] = PW'(999);
    pwr_valid = 1'b1;
    @(posedge clk); #1;
    pwr_valid = 1'b0;
    check("ovr_set", ovr, 1);
    send_frame(100, 8);
    send_frame(100, 12);
    drain(d0);
    check("ovr_sticky", ovr, 1);

    // 5. clr in ACCUM of the third frame, then four frames of 50
    send_frame(0, 1000);
    send_frame(0, 1000);
    send_frame(0, 1000);
    repeat (7) begin @(posedge clk); #1; end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("ovr_cleared", ovr, 0);
    d0 = done_cnt;
    push_exp(0, 50);
    for (int f = 0; f < 4; f++) send_frame(0, 50);
    drain(d0);
    check("ovr_after_clr_run", ovr, 0);

    // 6. async reset while bin 7 is presented
    push_exp(100, 6);
    for (int f = 0; f < 4; f++) send_frame(100, 4 * f);
    n = 0;
    while (!(out_valid && out_bin == 5'd7) && n < 60) begin @(posedge clk); #1; n++; end
    check("reach_bin7", out_bin, 7);
    #2 arstb = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_done", done, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 arstb = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    d0 = done_cnt;
    valid_seen = 0;
    send_frame(100, 0);
    repeat (40) begin @(posedge clk); #1; end
    check("single_frame_no_output", valid_seen, 0);
    check("single_frame_in_ready", in_ready, 1);
    check("single_frame_no_done", done_cnt - d0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
